// File: rtl/vxe_cu_prefetch_unit.sv
// Sequential 64-bit command prefetcher for the VxE control unit with credit-limited reads and redirect/drain.
// Optional statistics counters are enabled by defining VXE_CU_PREFETCH_STATS_EN.
module vxe_cu_prefetch_unit #(
  parameter logic [5:0] CLIENT_ID        = 6'd0,
  parameter int         FETCH_DEPTH_POW2 = 4,
  parameter int         OUTST_POW2       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rqa_rdy,
  output logic [43:0] o_rqa,
  output logic        o_rqa_wr,
  input  logic        i_rss_vld,
  input  logic [8:0]  i_rss,
  output logic        o_rss_rd,
  input  logic        i_rsd_vld,
  input  logic [63:0] i_rsd,
  output logic        o_rsd_rd,
  input  logic        i_start,
  input  logic [36:0] i_start_addr,
  input  logic        i_stop_drain,
  output logic        o_busy,
  output logic [36:0] o_fetch_addr,
  output logic [63:0] o_fetch_data,
  output logic        o_fetch_vld,
  output logic        o_fetch_err,
`ifdef VXE_CU_PREFETCH_STATS_EN
  output logic [31:0] o_stat_req,
  output logic [31:0] o_stat_stall,
`endif
  input  logic        i_fetch_rd
);

  localparam int            AW        = FETCH_DEPTH_POW2;
  localparam int            CW        = FETCH_DEPTH_POW2 + 1;
  localparam int            DEPTH_N   = 1 << FETCH_DEPTH_POW2;
  localparam logic [CW-1:0] DEPTH     = CW'(1 << FETCH_DEPTH_POW2);
  localparam logic [CW-1:0] MAX_OUTST = CW'(1 << OUTST_POW2);

  typedef enum logic [1:0] {IDLE, FETCH, ERR, DRAIN} state_t;

  state_t        state;
  logic [36:0]   req_addr;
  logic [36:0]   rsp_addr;
  logic [CW-1:0] outst;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] tail_cnt;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] outst_net;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [101:0]  mem [0:DEPTH_N-1];
  logic [101:0]  rsp_entry;

  logic          head_vld;
  logic [36:0]   head_addr;
  logic [63:0]   head_data;
  logic          head_err;

  logic rsp_take, rsp_err, rsp_dec, flush, credit, push, err_push, issue;
  logic pop, head_free, tail_pop, tail_push;
  logic unused_rss;

  assign unused_rss = ^i_rss[8:2];

  assign rsp_take  = i_rss_vld && i_rsd_vld;
  assign rsp_err   = |i_rss[1:0];
  assign rsp_dec   = rsp_take && (outst != '0);
  assign flush     = i_start || i_stop_drain;
  assign buf_count = tail_cnt + CW'(head_vld);
  assign credit    = ((outst + buf_count) < DEPTH) && (outst < MAX_OUTST);

  // A response lands in the buffer only while fetching and nothing stale is still ahead of it
  assign push      = rsp_take && !flush && (discard_cnt == '0) && (state == FETCH);
  assign err_push  = push && rsp_err;
  assign issue     = (state == FETCH) && i_rqa_rdy && credit && !flush && !err_push;
  assign outst_net = outst + CW'(issue) - CW'(rsp_dec);
  assign rsp_entry = {rsp_addr, i_rsd, rsp_err};

  assign pop       = i_fetch_rd && head_vld;
  assign head_free = !head_vld || pop;
  assign tail_pop  = head_free && (tail_cnt != '0);
  assign tail_push = push && !(head_free && (tail_cnt == '0));

  assign o_rqa        = issue ? {CLIENT_ID, 1'b1, req_addr} : '0;
  assign o_rqa_wr     = issue;
  assign o_rss_rd     = rsp_take;
  assign o_rsd_rd     = rsp_take;
  assign o_busy       = (state != IDLE);
  assign o_fetch_vld  = head_vld;
  assign o_fetch_addr = head_addr;
  assign o_fetch_data = head_data;
  assign o_fetch_err  = head_err;

  always_ff @(posedge clk) begin
    if (tail_push) mem[wr_ptr] <= rsp_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_addr    <= '0;
      rsp_addr    <= '0;
      outst       <= '0;
      discard_cnt <= '0;
      tail_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      head_vld    <= 1'b0;
      head_addr   <= '0;
      head_data   <= '0;
      head_err    <= 1'b0;
    end else begin
      outst <= outst_net;
      if (issue) req_addr <= req_addr + 37'd1;
      if (push)  rsp_addr <= rsp_addr + 37'd1;
      if (flush) begin
        // Everything still in flight becomes stale, including a response taken this cycle
        discard_cnt <= outst_net;
        tail_cnt    <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        head_vld    <= 1'b0;
        if (i_stop_drain) begin
          state <= DRAIN;
        end else begin
          state    <= FETCH;
          req_addr <= i_start_addr;
          rsp_addr <= i_start_addr;
        end
      end else begin
        if (rsp_take && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
        if (head_free) begin
          if (tail_cnt != '0) begin
            {head_addr, head_data, head_err} <= mem[rd_ptr];
            head_vld <= 1'b1;
          end else if (push) begin
            {head_addr, head_data, head_err} <= rsp_entry;
            head_vld <= 1'b1;
          end else begin
            head_vld <= 1'b0;
          end
        end
        if (tail_push) wr_ptr <= wr_ptr + AW'(1);
        if (tail_pop)  rd_ptr <= rd_ptr + AW'(1);
        tail_cnt <= tail_cnt + CW'(tail_push) - CW'(tail_pop);
        case (state)
          FETCH:   if (err_push) state <= ERR;
          ERR:     if ((outst == '0) && (buf_count == '0)) state <= IDLE;
          DRAIN:   if (outst == '0) state <= IDLE;
          default: state <= state;
        endcase
      end
    end
  end

`ifdef VXE_CU_PREFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      o_stat_req   <= '0;
      o_stat_stall <= '0;
    end else begin
      if (issue && (o_stat_req != '1)) o_stat_req <= o_stat_req + 32'd1;
      if ((state == FETCH) && (!i_rqa_rdy || !credit) && (o_stat_stall != '1))
        o_stat_stall <= o_stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vxe_cu_prefetch_unit.sv
// Self-checking bench for vxe_cu_prefetch_unit: directed scenarios plus a random phase,
// compared every cycle against a queue-based reference model of in-flight reads and the buffer.
module tb_vxe_cu_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rqa_rdy;
  logic [43:0] o_rqa;
  logic        o_rqa_wr;
  logic        i_rss_vld;
  logic [8:0]  i_rss;
  logic        o_rss_rd;
  logic        i_rsd_vld;
  logic [63:0] i_rsd;
  logic        o_rsd_rd;
  logic        i_start;
  logic [36:0] i_start_addr;
  logic        i_stop_drain;
  logic        o_busy;
  logic [36:0] o_fetch_addr;
  logic [63:0] o_fetch_data;
  logic        o_fetch_vld;
  logic        o_fetch_err;
  logic        i_fetch_rd;
`ifdef VXE_CU_PREFETCH_STATS_EN
  logic [31:0] o_stat_req;
  logic [31:0] o_stat_stall;
`endif

  always #5 clk = ~clk;

  vxe_cu_prefetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .i_rqa_rdy    (i_rqa_rdy),
    .o_rqa        (o_rqa),
    .o_rqa_wr     (o_rqa_wr),
    .i_rss_vld    (i_rss_vld),
    .i_rss        (i_rss),
    .o_rss_rd     (o_rss_rd),
    .i_rsd_vld    (i_rsd_vld),
    .i_rsd        (i_rsd),
    .o_rsd_rd     (o_rsd_rd),
    .i_start      (i_start),
    .i_start_addr (i_start_addr),
    .i_stop_drain (i_stop_drain),
    .o_busy       (o_busy),
    .o_fetch_addr (o_fetch_addr),
    .o_fetch_data (o_fetch_data),
    .o_fetch_vld  (o_fetch_vld),
    .o_fetch_err  (o_fetch_err),
`ifdef VXE_CU_PREFETCH_STATS_EN
    .o_stat_req   (o_stat_req),
    .o_stat_stall (o_stat_stall),
`endif
    .i_fetch_rd   (i_fetch_rd)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference model: buffered entries, in-flight reads with a stale mark, and the operating mode
  typedef struct { logic [36:0] addr; logic [63:0] data; logic err; } entry_t;
  typedef enum {M_IDLE, M_FETCH, M_ERR, M_DRAIN} mode_t;

  entry_t      exp_buf[$];
  logic [36:0] inflight_addr[$];
  bit          inflight_stale[$];
  logic [36:0] mem_q[$];
  mode_t       mode;
  logic [36:0] next_addr;
  logic [36:0] err_addr;
  bit          err_en;
  int          exp_req, exp_stall;
  int          rdy_pct, rsp_pct, rd_pct;

  // Memory contents are a fixed function of the word address
  function automatic logic [63:0] data_of(input logic [36:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[36:5]};
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    assert_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelClear();
    exp_buf.delete();
    inflight_addr.delete();
    inflight_stale.delete();
    mem_q.delete();
    mode      = M_IDLE;
    next_addr = '0;
    exp_req   = 0;
    exp_stall = 0;
  endtask

  // Reset the block and the memory side together, checking that every output is zero
  task automatic doReset();
    rst = 1'b1;
    i_rqa_rdy = 0; i_rss_vld = 0; i_rss = '0; i_rsd_vld = 0; i_rsd = '0;
    i_start = 0; i_start_addr = '0; i_stop_drain = 0; i_fetch_rd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rqa", o_rqa, 64'h0);
    checkOutput("rst_rqa_wr", o_rqa_wr, 64'h0);
    checkOutput("rst_rsp_rd", {o_rss_rd, o_rsd_rd}, 64'h0);
    checkOutput("rst_busy", o_busy, 64'h0);
    checkOutput("rst_fetch", {o_fetch_vld, o_fetch_err, o_fetch_addr}, 64'h0);
    checkOutput("rst_data", o_fetch_data, 64'h0);
`ifdef VXE_CU_PREFETCH_STATS_EN
    checkOutput("rst_stats", {o_stat_req, o_stat_stall}, 64'h0);
`endif
    modelClear();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model
  task automatic applyStimulus(input bit start, input logic [36:0] saddr, input bit stop);
    int          nin, nbuf;
    bit          take, pop, flush, credit, pushok, errpush, exp_issue;
    logic [36:0] a;

    i_start      = start;
    i_start_addr = start ? saddr : 37'({$urandom, $urandom});
    i_stop_drain = stop;
    i_rqa_rdy    = pct(rdy_pct);
    i_fetch_rd   = pct(rd_pct);
    if (mem_q.size() > 0 && pct(rsp_pct)) begin
      i_rss_vld = 1'b1;
      i_rsd_vld = 1'b1;
      i_rss     = (err_en && mem_q[0] == err_addr) ? 9'h3 : {7'($urandom), 2'b00};
      i_rsd     = data_of(mem_q[0]);
    end else begin
      i_rss_vld = ($urandom_range(3) == 0);
      i_rsd_vld = !i_rss_vld && ($urandom_range(3) == 0);
      i_rss     = 9'($urandom);
      i_rsd     = {$urandom, $urandom};
    end

    @(negedge clk);
    nin       = inflight_addr.size();
    nbuf      = exp_buf.size();
    take      = i_rss_vld && i_rsd_vld;
    pop       = i_fetch_rd && nbuf > 0;
    flush     = start || stop;
    credit    = (nin + nbuf < 16) && (nin < 8);
    pushok    = take && nin > 0 && mode == M_FETCH && !inflight_stale[0] && !flush;
    errpush   = pushok && err_en && inflight_addr[0] == err_addr;
    exp_issue = mode == M_FETCH && i_rqa_rdy && credit && !flush && !errpush;

    checkOutput("rqa_wr", o_rqa_wr, exp_issue);
    if (exp_issue) checkOutput("rqa", o_rqa, {20'd0, 6'd0, 1'b1, next_addr});
    checkOutput("rsp_rd", {o_rss_rd, o_rsd_rd}, {take, take});
    checkOutput("busy", o_busy, mode != M_IDLE);
    checkOutput("fetch_vld", o_fetch_vld, nbuf > 0);
    if (nbuf > 0) begin
      checkOutput("fetch_addr", o_fetch_addr, exp_buf[0].addr);
      checkOutput("fetch_data", o_fetch_data, exp_buf[0].data);
      checkOutput("fetch_err", o_fetch_err, exp_buf[0].err);
    end
`ifdef VXE_CU_PREFETCH_STATS_EN
    checkOutput("stat_req", o_stat_req, 64'(exp_req));
    checkOutput("stat_stall", o_stat_stall, 64'(exp_stall));
`endif

    if (take && mem_q.size() > 0) void'(mem_q.pop_front());
    if (o_rqa_wr) mem_q.push_back(o_rqa[36:0]);

    if (pop) void'(exp_buf.pop_front());
    if (take && nin > 0) begin
      a = inflight_addr.pop_front();
      void'(inflight_stale.pop_front());
      if (pushok) exp_buf.push_back('{addr: a, data: data_of(a), err: errpush});
    end
    if (exp_issue) begin
      inflight_addr.push_back(next_addr);
      inflight_stale.push_back(1'b0);
      next_addr = next_addr + 37'd1;
    end

    if (start) begin
      exp_req   = 0;
      exp_stall = 0;
    end else begin
      if (exp_issue) exp_req++;
      if (mode == M_FETCH && (!i_rqa_rdy || !credit)) exp_stall++;
    end

    if (stop || start) begin
      foreach (inflight_stale[i]) inflight_stale[i] = 1'b1;
      exp_buf.delete();
      if (stop) begin
        mode = M_DRAIN;
      end else begin
        mode      = M_FETCH;
        next_addr = saddr;
      end
    end else begin
      case (mode)
        M_FETCH: if (errpush) mode = M_ERR;
        M_ERR:   if (nin == 0 && nbuf == 0) mode = M_IDLE;
        M_DRAIN: if (nin == 0) mode = M_IDLE;
        default: ;
      endcase
    end

    @(posedge clk); #1;
    i_start      = 1'b0;
    i_stop_drain = 1'b0;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
  endtask

  // Step until the model reports idle, with a cycle budget
  task automatic runToIdle(input string tag, input int budget);
    int k;
    k = 0;
    while (mode != M_IDLE && k < budget) begin
      applyStimulus(1'b0, '0, 1'b0);
      k++;
    end
    checkOutput(tag, o_busy, 64'h0);
  endtask

  initial begin
    logic [36:0] sa;
    err_en = 0; err_addr = '0;
    rdy_pct = 0; rsp_pct = 0; rd_pct = 0;
    doReset();

    // Started but the request FIFO never accepts
    applyStimulus(1'b1, 37'h1, 1'b0);
    runCycles(8);

    // Normal streaming from address 1 with the consumer always reading
    rdy_pct = 100; rsp_pct = 70; rd_pct = 100;
    runCycles(100);

    // Consumer stalls: the buffer fills to its depth, then drains
    rd_pct = 0; rsp_pct = 100;
    runCycles(60);
    checkOutput("full_vld", o_fetch_vld, 64'h1);
    rd_pct = 100;
    runCycles(40);

    $display("[TB] stop and drain before the error scenario");
    applyStimulus(1'b0, '0, 1'b1);
    runToIdle("drain_idle", 100);

    // Third response reports an error
    err_en = 1; err_addr = 37'h3;
    rdy_pct = 100; rsp_pct = 100; rd_pct = 50;
    applyStimulus(1'b1, 37'h1, 1'b0);
    runToIdle("err_idle", 300);
    err_en = 0;

    // Redirect with five reads outstanding
    rsp_pct = 0; rd_pct = 0; rdy_pct = 100;
    applyStimulus(1'b1, 37'h40, 1'b0);
    runCycles(5);
    rdy_pct = 0;
    runCycles(2);
    checkOutput("outst5", 64'(mem_q.size()), 64'd5);
    rdy_pct = 100;
    applyStimulus(1'b1, 37'h100, 1'b0);
    rsp_pct = 100; rd_pct = 100;
    runCycles(40);

    // Stop with three outstanding, then restart at the top of the address space
    rsp_pct = 0; rd_pct = 100;
    applyStimulus(1'b1, 37'h200, 1'b0);
    runCycles(3);
    rdy_pct = 0;
    applyStimulus(1'b0, '0, 1'b1);
    rsp_pct = 100;
    runCycles(5);
    rdy_pct = 100;
    applyStimulus(1'b1, 37'h1F_FFFF_FFFF, 1'b0);
    runCycles(30);

    // Random traffic with redirects, stops, errors and one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        rdy_pct = $urandom_range(100);
        rsp_pct = $urandom_range(100);
        rd_pct  = $urandom_range(100);
      end
      if (i == 750) doReset();
      if ($urandom_range(39) == 0) begin
        sa = ($urandom_range(3) == 0) ? 37'h1F_FFFF_FFF0 + 37'($urandom_range(15))
                                      : 37'({$urandom, $urandom});
        err_en   = ($urandom_range(2) == 0);
        err_addr = sa + 37'($urandom_range(30));
        applyStimulus(1'b1, sa, ($urandom_range(7) == 0));
      end else if ($urandom_range(59) == 0) begin
        applyStimulus(1'b0, '0, 1'b1);
      end else begin
        applyStimulus(1'b0, '0, 1'b0);
      end
    end

    rsp_pct = 100; rd_pct = 100;
    applyStimulus(1'b0, '0, 1'b1);
    runToIdle("final_idle", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
